rps_round_ctrl: RTL and testbench

//  Round sequencer for the rock-paper-scissors display slave. Drives state, com_hand and

---
 rtl/rps_round_ctrl_pkg.sv | 30 +++
 rtl/rps_interval_timer.sv | 44 ++++
 rtl/rps_round_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_rps_round_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rps_round_ctrl_pkg.sv
// rtl/rps_round_ctrl_pkg.sv - shared codes and widths for the rock-paper-scissors round controller
//
// Purpose: hand, state and result encodings shared by the round controller
// and the VGA address generator, plus the interval timer width.
// Ports: none (package).
package rps_round_ctrl_pkg;

  // Width of the shared interval timer; wide enough for the default
  // 200M-cycle RESULT hold.
  localparam int TIMER_W = 32;

  // State encoding is fixed by the VGA memory map.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHUFFLE = 2'd1,
    ST_REVEAL  = 2'd2,
    ST_RESULT  = 2'd3
  } rps_state_e;

  localparam logic [1:0] HAND_ROCK     = 2'd0;
  localparam logic [1:0] HAND_PAPER    = 2'd1;
  localparam logic [1:0] HAND_SCISSORS = 2'd2;
  localparam logic [1:0] HAND_INVALID  = 2'd3;

  localparam logic [1:0] RES_NONE   = 2'd0;
  localparam logic [1:0] RES_PLAYER = 2'd1;
  localparam logic [1:0] RES_COM    = 2'd2;
  localparam logic [1:0] RES_DRAW   = 2'd3;

endpackage

// File: rtl/rps_interval_timer.sv
// rtl/rps_interval_timer.sv - loadable down-counter with a terminal-count pulse
//
// Purpose: counts enabled cycles after a load; done_o is high during the
// load_val_i-th enabled cycle after the load edge, so a state loaded on its
// entry edge and left on done_o lasts exactly load_val_i cycles.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load_i       load load_val_i (takes priority over en_i)
//   load_val_i   interval length in cycles (>=1 when used)
//   en_i         count this cycle
//   done_o       combinational terminal-count pulse
module rps_interval_timer
  import rps_round_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               en_i,
  output logic               done_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i && (cnt_q == TIMER_W'(1));

endmodule

// File: rtl/rps_round_ctrl.sv
// rtl/rps_round_ctrl.sv - round sequencer for the rock-paper-scissors display slave
//
// Purpose: runs shuffle -> reveal -> result per round, judges the hands,
// keeps scores and ends the match at WIN_SCORE. All outputs registered.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          begin round/match pulse (IDLE only)
//   hand_valid     player pick strobe, hand_in 0 rock 1 paper 2 scissors 3 invalid
//   state          0 IDLE 1 SHUFFLE 2 REVEAL 3 RESULT
//   com_hand       computer hand, rotating while shuffling
//   player_hand    latched player hand
//   result         0 none 1 player win 2 com win 3 draw
//   player_score   player round wins
//   com_score      computer round wins
//   match_over     high in IDLE once a score reached WIN_SCORE
//   busy           high when state != IDLE
module rps_round_ctrl
  import rps_round_ctrl_pkg::*;
#(
  parameter int SHUFFLE_DIV   = 2_500_000,
  parameter int REVEAL_CYCLES = 100_000_000,
  parameter int RESULT_CYCLES = 200_000_000,
  parameter int TIMEOUT       = 0,
  parameter int SCORE_W       = 4,
  parameter int WIN_SCORE     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hand_valid,
  input  logic [1:0]         hand_in,
  output logic [1:0]         state,
  output logic [1:0]         com_hand,
  output logic [1:0]         player_hand,
  output logic [1:0]         result,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] com_score,
  output logic               match_over,
  output logic               busy
);

  localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] STEP_LAST = TIMER_W'(SHUFFLE_DIV - 1);

  rps_state_e         state_q, state_d;
  logic [1:0]         com_q, com_d;
  logic [1:0]         player_q, player_d;
  logic [1:0]         result_q, result_d;
  logic [SCORE_W-1:0] pscore_q, pscore_d;
  logic [SCORE_W-1:0] cscore_q, cscore_d;
  logic               match_q, match_d;
  logic               busy_q, busy_d;
  logic [TIMER_W-1:0] step_q, step_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_en;
  logic               tmr_done;

  logic [2:0]         diff;
  logic [1:0]         judge;

  // One timer serves the SHUFFLE timeout, REVEAL hold and RESULT hold;
  // it is reloaded on every edge that enters one of those states.
  rps_interval_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .done_o     (tmr_done)
  );

  // (player - com) mod 3, biased by +3 so the subtraction never goes negative.
  always_comb begin
    diff = {1'b0, player_q} + 3'd3 - {1'b0, com_q};
    if (diff >= 3'd3) begin
      diff = diff - 3'd3;
    end
    case (diff)
      3'd1:    judge = RES_PLAYER;
      3'd2:    judge = RES_COM;
      default: judge = RES_DRAW;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    com_d    = com_q;
    player_d = player_q;
    result_d = result_q;
    pscore_d = pscore_q;
    cscore_d = cscore_q;
    match_d  = match_q;
    step_d   = step_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SHUFFLE;
          step_d   = '0;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(TIMEOUT);
          if (match_q) begin
            pscore_d = '0;
            cscore_d = '0;
            result_d = RES_NONE;
            match_d  = 1'b0;
          end
        end
      end

      ST_SHUFFLE: begin
        tmr_en = (TIMEOUT != 0);
        if (hand_valid && (hand_in != HAND_INVALID)) begin
          // com_hand is not stepped here, so a coincident wrap is dropped.
          player_d = hand_in;
          result_d = RES_NONE;
          state_d  = ST_REVEAL;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(REVEAL_CYCLES);
        end else if (tmr_done) begin
          state_d = ST_IDLE;
        end else if (step_q == STEP_LAST) begin
          step_d = '0;
          com_d  = (com_q == HAND_SCISSORS) ? HAND_ROCK : com_q + 2'd1;
        end else begin
          step_d = step_q + TIMER_W'(1);
        end
      end

      ST_REVEAL: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          state_d  = ST_RESULT;
          result_d = judge;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(RESULT_CYCLES);
          if ((judge == RES_PLAYER) && (pscore_q != WIN_S)) begin
            pscore_d = pscore_q + SCORE_W'(1);
          end
          if ((judge == RES_COM) && (cscore_q != WIN_S)) begin
            cscore_d = cscore_q + SCORE_W'(1);
          end
        end
      end

      ST_RESULT: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          if ((pscore_q == WIN_S) || (cscore_q == WIN_S)) begin
            match_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_SHUFFLE;
            step_d   = '0;
            tmr_load = 1'b1;
            tmr_val  = TIMER_W'(TIMEOUT);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      com_q    <= '0;
      player_q <= '0;
      result_q <= '0;
      pscore_q <= '0;
      cscore_q <= '0;
      match_q  <= 1'b0;
      busy_q   <= 1'b0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      com_q    <= com_d;
      player_q <= player_d;
      result_q <= result_d;
      pscore_q <= pscore_d;
      cscore_q <= cscore_d;
      match_q  <= match_d;
      busy_q   <= busy_d;
      step_q   <= step_d;
    end
  end

  assign state        = state_q;
  assign com_hand     = com_q;
  assign player_hand  = player_q;
  assign result       = result_q;
  assign player_score = pscore_q;
  assign com_score    = cscore_q;
  assign match_over   = match_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rps_round_ctrl.sv
// tb/tb_rps_round_ctrl.sv - self-checking bench for rps_round_ctrl
module tb_rps_round_ctrl;

  localparam int DIV = 4;
  localparam int REV = 3;
  localparam int RES = 5;
  localparam int WIN = 2;
  localparam int SW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, hand_valid;
  logic [1:0]    hand_in;
  logic [1:0]    state, com_hand, player_hand, result;
  logic [SW-1:0] player_score, com_score;
  logic          match_over, busy;

  logic          t_rst, t_start, t_hand_valid;
  logic [1:0]    t_hand_in;
  logic [1:0]    t_state, t_com_hand, t_player_hand, t_result;
  logic [SW-1:0] t_player_score, t_com_score;
  logic          t_match_over, t_busy;

  rps_round_ctrl #(
    .SHUFFLE_DIV(DIV), .REVEAL_CYCLES(REV), .RESULT_CYCLES(RES),
    .TIMEOUT(0), .SCORE_W(SW), .WIN_SCORE(WIN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hand_valid(hand_valid), .hand_in(hand_in),
    .state(state), .com_hand(com_hand), .player_hand(player_hand), .result(result),
    .player_score(player_score), .com_score(com_score),
    .match_over(match_over), .busy(busy)
  );

  rps_round_ctrl #(
    .SHUFFLE_DIV(DIV), .REVEAL_CYCLES(REV), .RESULT_CYCLES(RES),
    .TIMEOUT(10), .SCORE_W(SW), .WIN_SCORE(WIN)
  ) dut_to (
    .clk(clk), .rst(t_rst), .start(t_start), .hand_valid(t_hand_valid), .hand_in(t_hand_in),
    .state(t_state), .com_hand(t_com_hand), .player_hand(t_player_hand), .result(t_result),
    .player_score(t_player_score), .com_score(t_com_score),
    .match_over(t_match_over), .busy(t_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: state plus cycles elapsed since the entry edge.
  int m_state, m_age, m_base, m_com, m_player, m_result, m_ps, m_cs, m_match;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_step(input bit st, input bit hv, input int hin, input bit r);
    int d;
    if (r) begin
      m_state = 0; m_age = 0; m_base = 0; m_com = 0; m_player = 0;
      m_result = 0; m_ps = 0; m_cs = 0; m_match = 0;
      return;
    end
    case (m_state)
      0: if (st) begin
        if (m_match != 0) begin
          m_ps = 0; m_cs = 0; m_result = 0; m_match = 0;
        end
        m_state = 1; m_age = 0; m_base = m_com;
      end
      1: if (hv && hin != 3) begin
        m_player = hin; m_result = 0; m_state = 2; m_age = 0;
      end else begin
        m_age++;
        m_com = (m_base + m_age / DIV) % 3;
      end
      2: begin
        m_age++;
        if (m_age == REV) begin
          d = ((m_player - m_com) % 3 + 3) % 3;
          if (d == 0) m_result = 3;
          else if (d == 1) begin m_result = 1; if (m_ps < WIN) m_ps++; end
          else begin m_result = 2; if (m_cs < WIN) m_cs++; end
          m_state = 3; m_age = 0;
        end
      end
      default: begin
        m_age++;
        if (m_age == RES) begin
          if (m_ps == WIN || m_cs == WIN) begin
            m_match = 1; m_state = 0;
          end else begin
            m_state = 1; m_base = m_com;
          end
          m_age = 0;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("state", 32'(state), 32'(m_state));
    check("com_hand", 32'(com_hand), 32'(m_com));
    check("player_hand", 32'(player_hand), 32'(m_player));
    check("result", 32'(result), 32'(m_result));
    check("player_score", 32'(player_score), 32'(m_ps));
    check("com_score", 32'(com_score), 32'(m_cs));
    check("match_over", 32'(match_over), 32'(m_match));
    check("busy", 32'(busy), 32'(m_state != 0));
  endtask

  task automatic cycle(input bit st, input bit hv, input logic [1:0] hin, input bit r);
    start = st; hand_valid = hv; hand_in = hin; rst = r;
    @(posedge clk);
    m_step(st, hv, int'(hin), r);
    #1;
    compare_all();
    start = 1'b0; hand_valid = 1'b0; rst = 1'b0;
  endtask

  // Waits in SHUFFLE for the wanted com hand (any if want_com<0), optionally
  // on the cycle whose edge also steps com_hand; hin<0 picks the winning hand.
  task automatic hand_when(input int want_com, input bit on_step, input int hin);
    int n = 0;
    int h;
    while (!(m_state == 1 && (want_com < 0 || m_com == want_com) &&
             (!on_step || (m_age % DIV) == DIV - 1)) && n < 200) begin
      cycle(1'b0, 1'b0, 2'd0, 1'b0);
      n++;
    end
    check("wait_shuffle", 32'(n < 200), 32'd1);
    h = (hin < 0) ? (m_com + 1) % 3 : hin;
    cycle(1'b0, 1'b1, 2'(h), 1'b0);
  endtask

  task automatic wait_state(input int want);
    int n = 0;
    while (m_state != want && n < 200) begin
      cycle(1'b0, 1'b0, 2'd0, 1'b0);
      n++;
    end
    check("wait_state", 32'(n < 200), 32'd1);
  endtask

  task automatic t_cycle(input bit st, input bit hv, input logic [1:0] hin, input bit r);
    t_start = st; t_hand_valid = hv; t_hand_in = hin; t_rst = r;
    @(posedge clk);
    #1;
    t_start = 1'b0; t_hand_valid = 1'b0; t_rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hand_valid = 1'b0; hand_in = 2'd0;
    t_rst = 1'b1; t_start = 1'b0; t_hand_valid = 1'b0; t_hand_in = 2'd0;

    // 1: reset, start, shuffle rotation
    cycle(1'b0, 1'b0, 2'd0, 1'b1);
    check("reset_state", 32'(state), 32'd0);
    cycle(1'b1, 1'b0, 2'd0, 1'b0);
    check("start_shuffle", 32'(state), 32'd1);
    repeat (16) cycle(1'b0, 1'b0, 2'd0, 1'b0);

    // 2: scissors vs paper -> player win
    hand_when(1, 1'b0, 2);
    check("frozen_com", 32'(com_hand), 32'd1);
    wait_state(3);
    check("win_result", 32'(result), 32'd1);

    // 3: hand on a step edge from com=2, draw
    wait_state(1);
    hand_when(2, 1'b1, 2);
    check("step_discard", 32'(com_hand), 32'd2);
    wait_state(3);
    check("draw_result", 32'(result), 32'd3);

    // 4: win out the match, then restart
    for (int i = 0; i < 4 && m_match == 0; i++) begin
      wait_state(1);
      hand_when(-1, 1'b0, -1);
      wait_state(0);
    end
    check("match_over_set", 32'(match_over), 32'd1);
    cycle(1'b1, 1'b1, 2'd1, 1'b0);
    check("match_cleared", 32'(player_score), 32'd0);

    // 5: invalid hand in SHUFFLE, hand in RESULT
    cycle(1'b0, 1'b1, 2'd3, 1'b0);
    hand_when(-1, 1'b0, 0);
    wait_state(3);
    cycle(1'b0, 1'b1, 2'd1, 1'b0);

    // 6: start and reset during REVEAL
    wait_state(1);
    hand_when(-1, 1'b0, 1);
    cycle(1'b1, 1'b0, 2'd0, 1'b0);
    cycle(1'b0, 1'b0, 2'd0, 1'b1);
    check("rst_reveal", 32'(state), 32'd0);

    // random phase
    for (int i = 0; i < 4000; i++) begin
      cycle(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 5) == 0),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 599) == 0));
    end

    // TIMEOUT=10 instance: one won round, then abandon the next shuffle
    t_cycle(1'b0, 1'b0, 2'd0, 1'b1);
    t_cycle(1'b1, 1'b0, 2'd0, 1'b0);
    check("to_start", 32'(t_state), 32'd1);
    t_cycle(1'b0, 1'b1, 2'd1, 1'b0);
    check("to_reveal", 32'(t_state), 32'd2);
    repeat (3) t_cycle(1'b0, 1'b0, 2'd0, 1'b0);
    check("to_result", 32'(t_state), 32'd3);
    check("to_score1", 32'(t_player_score), 32'd1);
    repeat (5) t_cycle(1'b0, 1'b0, 2'd0, 1'b0);
    check("to_reshuffle", 32'(t_state), 32'd1);
    t_cycle(1'b0, 1'b1, 2'd3, 1'b0);
    repeat (8) t_cycle(1'b0, 1'b0, 2'd0, 1'b0);
    check("to_not_yet", 32'(t_state), 32'd1);
    t_cycle(1'b0, 1'b0, 2'd0, 1'b0);
    check("to_abort", 32'(t_state), 32'd0);
    check("to_score_kept", 32'(t_player_score), 32'd1);
    check("to_match_kept", 32'(t_match_over), 32'd0);
    check("to_busy", 32'(t_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
